// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // funct3 encodings for loads and stores
  typedef enum logic [2:0] {
    AC_B  = 3'b000,
    AC_H  = 3'b001,
    AC_W  = 3'b010,
    AC_BU = 3'b100,
    AC_HU = 3'b101
  } access_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  localparam int LSU_TIMEOUT_DEFAULT = 64;
  localparam int NUM_LANES           = 4;
  localparam int LANE_W              = 8;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store be/wdata generation with legality check,
// and load byte/half extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic                            st_read,
  input  logic                            st_write,
  input  logic [2:0]                      st_ctrl,
  input  logic [1:0]                      st_off,
  input  logic [NUM_LANES*LANE_W-1:0]     st_data,
  output logic [NUM_LANES-1:0]            st_be,
  output logic [NUM_LANES*LANE_W-1:0]     st_wdata,
  output logic                            st_fault,
  input  logic [2:0]                      ld_ctrl,
  input  logic [1:0]                      ld_off,
  input  logic [NUM_LANES*LANE_W-1:0]     ld_word,
  output logic [NUM_LANES*LANE_W-1:0]     ld_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] data_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0] rep_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;
  logic [LANE_W-1:0]                ld_byte;
  logic [2*LANE_W-1:0]              ld_half;

  assign data_lanes = st_data;
  assign rd_lanes   = ld_word;

  // Each lane picks its source byte: byte 0 for SB, byte i%2 for SH, byte i for SW
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign rep_lanes[i] = (st_ctrl == AC_B) ? data_lanes[0]     :
                          (st_ctrl == AC_H) ? data_lanes[i % 2] :
                                              data_lanes[i];
  end

  // Store/load legality and byte enables for the access in IDLE
  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    st_fault = 1'b0;
    if (st_read && st_write) begin
      st_fault = 1'b1;
    end else if (st_write) begin
      st_wdata = rep_lanes;
      case (st_ctrl)
        AC_B:    st_be = 4'b0001 << st_off;
        AC_H:    begin st_be = st_off[1] ? 4'b1100 : 4'b0011; st_fault = st_off[0]; end
        AC_W:    begin st_be = 4'b1111; st_fault = |st_off; end
        default: st_fault = 1'b1;
      endcase
    end else if (st_read) begin
      st_be = 4'b1111;
      case (st_ctrl)
        AC_B, AC_BU: st_fault = 1'b0;
        AC_H, AC_HU: st_fault = st_off[0];
        AC_W:        st_fault = |st_off;
        default:     st_fault = 1'b1;
      endcase
    end
  end

  assign ld_byte = rd_lanes[ld_off];
  assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  // Extract and extend the loaded element from the response word
  always_comb begin
    ld_data = ld_word;
    case (ld_ctrl)
      AC_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      AC_BU:   ld_data = {24'h0, ld_byte};
      AC_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      AC_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns core memory accesses into single
// outstanding bus transactions, stalling the core until they retire.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  access_ctrl_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       be_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       off_q;
  logic             we_q, to_q;

  logic             acc, start, flt;
  logic [3:0]       a_be;
  logic [31:0]      a_wdata, ld_data;
  logic             a_fault;

  // Inputs only matter in IDLE and never while reset is held
  assign acc   = !rst && (state == ST_IDLE) && (mem_read_i || mem_write_i);
  assign start = acc && !a_fault;
  assign flt   = acc && a_fault;

  lsu_align u_align (
    .st_read  (mem_read_i),
    .st_write (mem_write_i),
    .st_ctrl  (access_ctrl_i),
    .st_off   (addr_i[1:0]),
    .st_data  (write_data_i),
    .st_be    (a_be),
    .st_wdata (a_wdata),
    .st_fault (a_fault),
    .ld_ctrl  (ctrl_q),
    .ld_off   (off_q),
    .ld_word  (bus_rdata_i),
    .ld_data  (ld_data)
  );

  // Transaction FSM with shared REQ/WAIT timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      ctrl_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            off_q   <= addr_i[1:0];
            be_q    <= a_be;
            wdata_q <= a_wdata;
            ctrl_q  <= access_ctrl_i;
            we_q    <= mem_write_i;
            to_q    <= 1'b0;
            cnt     <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else if (cnt == CNT_LAST) begin
            to_q  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            rdata_q <= we_q ? '0 : ld_data;
            state   <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            to_q  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_o     = start || (state == ST_REQ) || (state == ST_WAIT);
  assign done_o      = flt || (state == ST_DONE);
  assign fault_o     = flt || ((state == ST_DONE) && to_q);
  assign read_data_o = ((state == ST_DONE) && !to_q) ? rdata_q : '0;
  assign bus_req_o   = (state == ST_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected retirements
// and bus requests; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, write_data_i;
  logic [2:0]  access_ctrl_i;
  logic [31:0] read_data_o;
  logic        stall_o, done_o, fault_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .access_ctrl_i(access_ctrl_i),
    .read_data_o(read_data_o), .stall_o(stall_o), .done_o(done_o), .fault_o(fault_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic fault; logic [31:0] data; int stalls; int reqs; } rsp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } breq_t;

  rsp_t  rsp_q[$];
  breq_t bus_q[$];
  int    checks = 0, errors = 0;

  int          gnt_wait = 0, rv_wait = 0;
  bit          gnt_never = 0, rv_never = 0, stray = 0;
  logic [31:0] rsp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bus responder: grant after gnt_wait cycles, respond rv_wait cycles after grant
  int gcnt = 0, rcnt = 0;
  bit pend = 0;
  initial begin
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt_i = 0; bus_rvalid_i = 0;
      if (rst || done_o) begin
        pend = 0; gcnt = 0;
      end else if (stray) begin
        bus_rvalid_i = 1; bus_rdata_i = 32'hBAD0BAD0;
      end else if (pend) begin
        if (!rv_never) begin
          if (rcnt >= rv_wait) begin
            bus_rvalid_i = 1; bus_rdata_i = rsp_data; pend = 0;
          end else rcnt++;
        end
      end else if (bus_req_o && !gnt_never) begin
        if (gcnt >= gnt_wait) begin
          bus_gnt_i = 1; pend = 1; rcnt = 0; gcnt = 0;
        end else gcnt++;
      end
    end
  end

  // Monitor: compare accepted bus requests and retirements against the queues
  int st_cnt = 0, rq_cnt = 0;
  initial begin
    rsp_t  r;
    breq_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_cnt = 0; rq_cnt = 0;
      end else begin
        if (stall_o)   st_cnt++;
        if (bus_req_o) rq_cnt++;
        if (bus_req_o && bus_gnt_i) begin
          chk("grant_expected", 32'(bus_q.size() > 0), 32'd1);
          if (bus_q.size() > 0) begin
            b = bus_q.pop_front();
            chk("bus_addr", bus_addr_o, b.addr);
            chk("bus_be", 32'(bus_be_o), 32'(b.be));
            chk("bus_we", 32'(bus_we_o), 32'(b.we));
            if (b.we) chk("bus_wdata", bus_wdata_o, b.wdata);
          end
        end
        if (done_o) begin
          chk("done_expected", 32'(rsp_q.size() > 0), 32'd1);
          chk("stall_at_done", 32'(stall_o), 32'd0);
          if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            chk("fault", 32'(fault_o), 32'(r.fault));
            chk("read_data", read_data_o, r.data);
            chk("stall_cycles", 32'(st_cnt), 32'(r.stalls));
            chk("req_cycles", 32'(rq_cnt), 32'(r.reqs));
          end
          st_cnt = 0; rq_cnt = 0;
        end
      end
    end
  end

  // Issue one access, push its expectations, hold inputs until it retires
  task automatic access(input bit rd, input bit wr, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gw, input int rw, input bit gn, input bit rn,
                        input logic [31:0] rdat,
                        input bit e_fault, input logic [31:0] e_data,
                        input int e_st, input int e_rq,
                        input bit e_bus, input logic [31:0] b_addr,
                        input logic [3:0] b_be, input logic [31:0] b_wd);
    rsp_t  r;
    breq_t b;
    bit    seen;
    r.fault = e_fault; r.data = e_data; r.stalls = e_st; r.reqs = e_rq;
    rsp_q.push_back(r);
    if (e_bus) begin
      b.addr = b_addr; b.be = b_be; b.we = wr; b.wdata = b_wd;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    gnt_wait = gw; rv_wait = rw; gnt_never = gn; rv_never = rn; rsp_data = rdat;
    mem_read_i = rd; mem_write_i = wr; access_ctrl_i = ctrl;
    addr_i = addr; write_data_i = wd;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    mem_read_i = 0; mem_write_i = 0;
    gnt_never = 0; rv_never = 0; gnt_wait = 0; rv_wait = 0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1;
    mem_read_i = 1; mem_write_i = 0; addr_i = 32'h100; write_data_i = '0;
    access_ctrl_i = 3'b010;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    chk("rst_be", 32'(bus_be_o), 32'd0);
    mem_read_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // loads: rd wr ctrl addr wd gw rw gn rn rdata | fault data stalls reqs | bus addr be wdata
    access(1,0,3'b010,32'h100,0, 0,0,0,0,32'hDEADBEEF, 0,32'hDEADBEEF,3,1, 1,32'h100,4'hF,0);
    access(1,0,3'b000,32'h103,0, 0,0,0,0,32'h80FFFFFF, 0,32'hFFFFFF80,3,1, 1,32'h100,4'hF,0);
    access(1,0,3'b100,32'h103,0, 1,0,0,0,32'h80FFFFFF, 0,32'h00000080,4,2, 1,32'h100,4'hF,0);
    access(1,0,3'b101,32'h102,0, 0,1,0,0,32'h80FFFFFF, 0,32'h000080FF,4,1, 1,32'h100,4'hF,0);
    access(1,0,3'b001,32'h102,0, 0,0,0,0,32'h80FFFFFF, 0,32'hFFFF80FF,3,1, 1,32'h100,4'hF,0);
    access(1,0,3'b000,32'h100,0, 0,0,0,0,32'h1234567F, 0,32'h0000007F,3,1, 1,32'h100,4'hF,0);
    // stores
    access(0,1,3'b000,32'h201,32'h12345678, 1,2,0,0,0, 0,0,6,2, 1,32'h200,4'b0010,32'h78787878);
    access(0,1,3'b001,32'h302,32'hCAFEBABE, 0,0,0,0,0, 0,0,3,1, 1,32'h300,4'b1100,32'hBABEBABE);
    access(0,1,3'b010,32'h404,32'h0BADF00D, 0,0,0,0,0, 0,0,3,1, 1,32'h404,4'b1111,32'h0BADF00D);
    // faults: misaligned, both directions, illegal codes
    access(1,0,3'b010,32'h102,0, 0,0,0,0,0, 1,0,0,0, 0,0,0,0);
    access(0,1,3'b001,32'h101,32'h5555, 0,0,0,0,0, 1,0,0,0, 0,0,0,0);
    access(1,1,3'b010,32'h100,0, 0,0,0,0,0, 1,0,0,0, 0,0,0,0);
    access(1,0,3'b011,32'h100,0, 0,0,0,0,0, 1,0,0,0, 0,0,0,0);
    access(0,1,3'b100,32'h100,0, 0,0,0,0,0, 1,0,0,0, 0,0,0,0);
    // timeouts: grant withheld, then response withheld
    access(1,0,3'b010,32'h500,0, 0,0,1,0,0, 1,0,5,4, 0,0,0,0);
    access(1,0,3'b010,32'h600,0, 0,0,0,1,32'h77777777, 1,0,6,1, 1,32'h600,4'hF,0);

    // reset while in WAIT
    bus_q.push_back('{addr:32'h700, be:4'hF, we:1'b0, wdata:32'h0});
    @(posedge clk); #1;
    rv_never = 1; mem_read_i = 1; access_ctrl_i = 3'b010; addr_i = 32'h700;
    @(posedge clk);
    @(posedge clk);
    #3; rst = 1; #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_addr", bus_addr_o, 32'd0);
    mem_read_i = 0; rv_never = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk); stray = 1;
    @(negedge clk); stray = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_done", 32'(done_o), 32'd0);
      chk("stray_stall", 32'(stall_o), 32'd0);
    end
    access(1,0,3'b010,32'h700,0, 0,0,0,0,32'h11223344, 0,32'h11223344,3,1, 1,32'h700,4'hF,0);

    repeat (3) @(negedge clk);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the RISC-V core, sitting directly downstream of the datapath's ALU/register-file outputs. It replaces the zero-latency on-chip data memory with a request/response bus to external data memory or peripherals. It holds the core with `stall_o` while a transaction is outstanding. It handles byte-lane steering, load sign/zero extension, misalignment detection and a response timeout.

## Interface
- `TIMEOUT_CYCLES`, default 64: max cycles in REQ or WAIT before abort; must be ≥ 2.
- `clk` input 1: core clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_read_i` input 1: load requested by current instruction.
- `mem_write_i` input 1: store requested by current instruction.
- `addr_i` input 32: byte address, ALU result.
- `write_data_i` input 32: store data, rs2 value.
- `access_ctrl_i` input 3: funct3 encoding.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Other codes are illegal.
- `read_data_o` output 32: extended load result, valid when `done_o`.
- `stall_o` output 1: core must hold PC and all state.
- `done_o` output 1: one-cycle pulse, access retires this cycle.
- `fault_o` output 1: one-cycle pulse for a misaligned, illegal or timed-out access.
- `bus_req_o` output 1: request valid.
- `bus_we_o` output 1: 1 = write.
- `bus_addr_o` output 32: word-aligned address, bits [1:0] = 0.
- `bus_be_o` output 4: byte enables; all ones for reads.
- `bus_wdata_o` output 32: lane-steered store data.
- `bus_gnt_i` input 1: request accepted this cycle.
- `bus_rvalid_i` input 1: response valid; acknowledges writes too.
- `bus_rdata_i` input 32: read response word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no access: `stall_o` = 0. Any `bus_rvalid_i` is ignored.
- IDLE, legal and aligned access:
  - Latch aligned address, byte enables, steered write data, ctrl, and direction.
  - Assert `stall_o` combinationally.
  - Next state REQ.
- IDLE, fault:
  - Faulting cases:
    - both read and write set;
    - illegal ctrl code;
    - LH/LHU/SH with `addr_i[0]` = 1;
    - LW/SW with `addr_i[1:0]` ≠ 0.
  - `fault_o` = 1 and `done_o` = 1 in that same cycle. `stall_o` = 0 and `read_data_o` = 0.
  - No bus activity; a store is dropped.
  - Stay in IDLE.
- REQ: `bus_req_o` = 1, with all bus fields held stable from registers. On `bus_gnt_i`, go to WAIT.
- WAIT: `bus_req_o` = 0. On `bus_rvalid_i`, register the extended load data and go to DONE.
- DONE: `stall_o` = 0, `done_o` = 1, `read_data_o` valid. Unconditionally return to IDLE.
  - The still-asserted `mem_*_i` of the retiring instruction is not re-sampled.
- Timeout:
  - One counter, cleared on entry to REQ and on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` in REQ or WAIT, drop `bus_req_o` and go to DONE.
  - In DONE after a timeout: `fault_o` = 1 and `read_data_o` = 0.
- Lane rules, byte offset o = `addr_i[1:0]`:
  - SB: be = 1<<o, wdata = byte replicated ×4.
  - SH: be = 0011 or 1100, wdata = half replicated ×2.
  - SW: be = 1111.
  - Loads extract the byte/half at o; LB/LH sign-extend, LBU/LHU zero-extend.

## Timing
- Reset values:
  - All outputs 0, state IDLE, counter 0.
  - `stall_o` is 0 after reset because state is IDLE and the inputs are ignored while `rst` = 1.
- Reset mid-transaction: immediate return to IDLE. `bus_req_o` drops asynchronously and a later stray `bus_rvalid_i` is ignored.
- Minimum latency, with access first seen in cycle T:
  - `bus_gnt_i` at T+1 (REQ).
  - `bus_rvalid_i` at T+2 (WAIT).
  - DONE at T+3; the instruction retires at the end of T+3.
  - `stall_o` is high in T, T+1 and T+2.
- Each wait cycle of `bus_gnt_i` or `bus_rvalid_i` adds exactly one cycle.
- Bus contract:
  - At most one outstanding transaction.
  - `bus_rvalid_i` no earlier than the cycle after the grant.
  - `bus_rvalid_i` in REQ or IDLE is ignored.

## Structure
- Package `lsu_pkg`:
  - `access_ctrl_t` enum with the funct3 codes above.
  - `lsu_state_t` enum.
  - Default timeout constant.
- Sub-module `lsu_align`, combinational:
  - store path: be/wdata generation plus misalignment/illegal flag;
  - load path: extract/extend from word and offset.
  - Instantiated once and used by both paths.
- `load_store_unit` holds the FSM, the registers and the timeout counter.

## Test plan
- LW at 0x100, gnt at T+1, rvalid at T+2 with rdata 0xDEADBEEF → `stall_o` high T..T+2, `done_o` at T+3, `read_data_o` = 0xDEADBEEF, `bus_be_o` = 1111.
- LB at 0x103 with rdata 0x80FF_FFFF → 0xFFFFFF80. LBU → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB 0x12345678 at 0x201 → `bus_addr_o` = 0x200, `bus_be_o` = 0010, `bus_wdata_o` = 0x78787878, `bus_we_o` = 1, completes on rvalid.
- LW at 0x102 or SH at 0x101 → `fault_o` and `done_o` same cycle, no `bus_req_o`, `stall_o` = 0. Same for both read and write set, and for ctrl 011.
- `TIMEOUT_CYCLES` = 4 with gnt never asserted → `bus_req_o` for 4 cycles, then DONE with `fault_o` = 1 and `read_data_o` = 0. Repeat with gnt given but rvalid withheld.
- Assert `rst` while in WAIT → outputs 0 immediately. A following rvalid is ignored, and a new LW proceeds normally.
